// File: rtl/spi_flash_pkg.sv
// Shared SPI flash definitions: opcodes, frame timing and FSM encoding.
package spi_flash_pkg;

   localparam logic [7:0] OP_WREN   = 8'h06;
   localparam logic [7:0] OP_PP     = 8'h02;
   localparam int         BYTE_CLKS = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WREN,
      ST_GAP,
      ST_PP,
      ST_DONE
   } state_e;

endpackage

// File: rtl/key_filter.sv
// Push-button debouncer: one key_flag pulse once key_in has been low
// for CNT_MAX-1 consecutive clocks.
module key_filter #(
   parameter int CNT_MAX = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_in,
   output logic key_flag
);

   localparam int CW = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] TOP = CW'(CNT_MAX - 1);
   localparam logic [CW-1:0] PRE = CW'(CNT_MAX - 2);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          flag_q, flag_d;

   // Flag is registered so it coincides with the counter hitting TOP.
   always_comb begin
      cnt_d  = cnt_q;
      flag_d = 1'b0;
      if (key_in) begin
         cnt_d = '0;
      end else begin
         if (cnt_q != TOP) cnt_d = cnt_q + CW'(1);
         flag_d = (cnt_q == PRE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         flag_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
      end
   end

   assign key_flag = flag_q;

endmodule

// File: rtl/spi_page_program.sv
// Key-triggered SPI flash page program: WREN frame, gap, then PP frame
// carrying ADDR and an incrementing byte pattern.
module spi_page_program
   import spi_flash_pkg::*;
#(
   parameter int          CNT_MAX  = 1_000_000,
   parameter logic [23:0] ADDR     = 24'h00_04_25,
   parameter int          DATA_NUM = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key,
   output logic       cs,
   output logic       spi_clk,
   output logic       spi_mosi,
   output logic [3:0] led_out
);

   localparam int CW = 14;
   localparam logic [CW-1:0] WREN_LAST = CW'(3 * BYTE_CLKS - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(BYTE_CLKS - 1);
   localparam logic [CW-1:0] PP_LAST   = CW'((DATA_NUM + 6) * BYTE_CLKS - 1);
   localparam logic [8:0]    PP_BYTES  = 9'(DATA_NUM + 4);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          cs_q, cs_d;
   logic          sclk_q, sclk_d;
   logic          mosi_q, mosi_d;
   logic          trig;

   logic [8:0]    slot;
   logic [8:0]    byte_idx;
   logic [2:0]    bit_i;
   logic [8:0]    nbytes;
   logic          framing;
   logic          data_slot;
   logic [7:0]    cur_byte;

   key_filter #(.CNT_MAX(CNT_MAX)) u_key_filter (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_in   (key),
      .key_flag (trig)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            cnt_d = '0;
            if (trig) state_d = ST_WREN;
         end
         ST_WREN: if (cnt_q == WREN_LAST) begin
            state_d = ST_GAP;
            cnt_d   = '0;
         end
         ST_GAP: if (cnt_q == GAP_LAST) begin
            state_d = ST_PP;
            cnt_d   = '0;
         end
         ST_PP: if (cnt_q == PP_LAST) begin
            state_d = ST_DONE;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Slot 0 and the last slot are idle; slots in between carry bytes.
   assign slot      = cnt_q[CW-1:5];
   assign bit_i     = cnt_q[4:2];
   assign byte_idx  = slot - 9'd1;
   assign framing   = (state_q == ST_WREN) || (state_q == ST_PP);
   assign nbytes    = (state_q == ST_PP) ? PP_BYTES : 9'd1;
   assign data_slot = framing && (slot != 9'd0) && (slot <= nbytes);

   always_comb begin
      cur_byte = OP_WREN;
      if (state_q == ST_PP) begin
         unique case (1'b1)
            byte_idx == 9'd0: cur_byte = OP_PP;
            byte_idx == 9'd1: cur_byte = ADDR[23:16];
            byte_idx == 9'd2: cur_byte = ADDR[15:8];
            byte_idx == 9'd3: cur_byte = ADDR[7:0];
            default:          cur_byte = 8'(byte_idx - 9'd4);
         endcase
      end
   end

   always_comb begin
      cs_d   = !framing;
      sclk_d = data_slot && cnt_q[1];
      mosi_d = data_slot && cur_byte[3'd7 - bit_i];
   end

   always_comb begin
      led_out = 4'b0000;
      unique case (state_q)
         ST_WREN, ST_GAP: led_out = 4'b0001;
         ST_PP:           led_out = 4'b0011;
         ST_DONE:         led_out = 4'b1111;
         default:         led_out = 4'b0000;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cs_q    <= 1'b1;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cs_q    <= cs_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
      end
   end

   assign cs       = cs_q;
   assign spi_clk  = sclk_q;
   assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_page_program.sv
// Bench: random bouncing presses, SPI frames decoded and compared with
// the expected WREN / page-program byte streams.
module tb_spi_page_program;

   localparam int          CNT_MAX  = 200;
   localparam logic [23:0] ADDR     = 24'h00_04_25;
   localparam int          DATA_NUM = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key = 1'b1;
   logic       cs;
   logic       spi_clk;
   logic       spi_mosi;
   logic [3:0] led_out;

   int checks = 0;
   int errors = 0;

   spi_page_program #(
      .CNT_MAX  (CNT_MAX),
      .ADDR     (ADDR),
      .DATA_NUM (DATA_NUM)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .key      (key),
      .cs       (cs),
      .spi_clk  (spi_clk),
      .spi_mosi (spi_mosi),
      .led_out  (led_out)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Bus monitor: decodes frames and measures timing on each negedge.
   int         cyc = 0;
   int         last_rise = 0;
   int         last_fall = 0;
   int         cs_fall_cyc = 0;
   int         cs_rise_cyc = 0;
   int         nbits = 0;
   int         hi_run = 0;
   int         rises = 0;
   int         bad_period = 0;
   int         bad_duty = 0;
   int         bad_stable = 0;
   int         bad_idle = 0;
   int         partial = 0;
   logic [7:0] sh = '0;
   logic [7:0] cur_q[$];
   logic [7:0] frames_q[$];
   int         flen_q[$];
   int         gap_q[$];
   int         lead_q[$];
   int         tail_q[$];
   logic [3:0] led_seq[$];
   logic       p_sclk = 1'b0;
   logic       p_cs = 1'b1;
   logic       p_mosi = 1'b0;
   logic [3:0] p_led = 4'b0000;

   always @(negedge clk) begin
      cyc++;
      if (cs && (spi_clk || spi_mosi)) bad_idle++;
      if (p_cs && !cs) begin
         gap_q.push_back(cyc - cs_rise_cyc);
         cs_fall_cyc = cyc;
         nbits = 0;
         cur_q.delete();
      end
      if (!p_sclk && spi_clk) begin
         rises++;
         if (!cs) begin
            if (nbits == 0) lead_q.push_back(cyc - cs_fall_cyc);
            else if (cyc - last_rise != 4) bad_period++;
            if (spi_mosi !== p_mosi) bad_stable++;
            last_rise = cyc;
            sh = {sh[6:0], spi_mosi};
            nbits++;
            if (nbits % 8 == 0) cur_q.push_back(sh);
         end
      end
      if (spi_clk) hi_run++;
      if (p_sclk && !spi_clk) begin
         if (hi_run != 2) bad_duty++;
         hi_run = 0;
         last_fall = cyc;
      end
      if (!p_cs && cs) begin
         cs_rise_cyc = cyc;
         tail_q.push_back(cyc - last_fall);
         flen_q.push_back(cur_q.size());
         foreach (cur_q[i]) frames_q.push_back(cur_q[i]);
         if (nbits % 8 != 0) partial++;
      end
      if (led_out != p_led) led_seq.push_back(led_out);
      p_sclk = spi_clk;
      p_cs   = cs;
      p_mosi = spi_mosi;
      p_led  = led_out;
   end

   task automatic clear_mon();
      @(posedge clk);
      #1;
      frames_q.delete();
      flen_q.delete();
      gap_q.delete();
      lead_q.delete();
      tail_q.delete();
      led_seq.delete();
   endtask

   task automatic press(input int low_cycles);
      int nb;
      nb = $urandom_range(1, 6);
      for (int i = 0; i < nb; i++) begin
         @(negedge clk) key = 1'b0;
         repeat ($urandom_range(1, 5)) @(negedge clk);
         key = 1'b1;
         repeat ($urandom_range(1, 5)) @(negedge clk);
      end
      key = 1'b0;
      repeat (low_cycles) @(negedge clk);
      nb = $urandom_range(1, 6);
      for (int i = 0; i < nb; i++) begin
         key = 1'b1;
         repeat ($urandom_range(1, 5)) @(negedge clk);
         key = 1'b0;
         repeat ($urandom_range(1, 5)) @(negedge clk);
      end
      key = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic wait_led(input logic [3:0] v, input int limit,
                           input string tag);
      int n;
      n = 0;
      while (led_out !== v && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(led_out), 32'(v));
   endtask

   logic [7:0] exp_q[$];

   task automatic check_sequence(input string pfx);
      int n;
      chk({pfx, "_nframes"}, flen_q.size(), 2);
      if (flen_q.size() == 2) begin
         chk({pfx, "_wren_len"}, flen_q[0], 1);
         chk({pfx, "_pp_len"}, flen_q[1], 4 + DATA_NUM);
      end
      chk({pfx, "_nbytes"}, frames_q.size(), exp_q.size());
      n = (frames_q.size() < exp_q.size()) ? frames_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_byte%0d", pfx, i), 32'(frames_q[i]), 32'(exp_q[i]));
      if (gap_q.size() >= 2) chk({pfx, "_cs_gap"}, gap_q[1], 32);
      else chk({pfx, "_ngaps"}, gap_q.size(), 2);
      foreach (lead_q[i]) chk({pfx, "_lead_idle"}, lead_q[i], 34);
      foreach (tail_q[i]) chk({pfx, "_tail_idle"}, tail_q[i], 32);
      chk({pfx, "_led_steps"}, led_seq.size(), 3);
      if (led_seq.size() == 3) begin
         chk({pfx, "_led0"}, 32'(led_seq[0]), 32'h1);
         chk({pfx, "_led1"}, 32'(led_seq[1]), 32'h3);
         chk({pfx, "_led2"}, 32'(led_seq[2]), 32'hf);
      end
   endtask

   initial begin
      int rises_at_rst;
      exp_q.push_back(8'h06);
      exp_q.push_back(8'h02);
      exp_q.push_back(ADDR[23:16]);
      exp_q.push_back(ADDR[15:8]);
      exp_q.push_back(ADDR[7:0]);
      for (int i = 0; i < DATA_NUM; i++) exp_q.push_back(8'(i));

      repeat (3) @(negedge clk);
      chk("rst_cs", 32'(cs), 32'h1);
      chk("rst_led", 32'(led_out), 32'h0);
      @(negedge clk) rst_n = 1'b1;
      repeat (50) @(negedge clk);
      chk("idle_cs", 32'(cs), 32'h1);
      chk("idle_sclk", 32'(spi_clk), 32'h0);
      chk("idle_mosi", 32'(spi_mosi), 32'h0);
      chk("idle_led", 32'(led_out), 32'h0);

      clear_mon();
      press($urandom_range(1, CNT_MAX / 4));
      press(CNT_MAX - 2);
      repeat (100) @(negedge clk);
      chk("short_frames", flen_q.size(), 0);
      chk("short_cs", 32'(cs), 32'h1);
      chk("short_led", 32'(led_out), 32'h0);

      clear_mon();
      press(CNT_MAX - 1 + $urandom_range(0, 20));
      wait_led(4'hf, 2000, "first_done");
      repeat (200) @(negedge clk);
      check_sequence("first");

      clear_mon();
      press(CNT_MAX - 1 + $urandom_range(0, 20));
      wait_led(4'h3, 2000, "second_pp");
      repeat ($urandom_range(0, 100)) @(negedge clk);
      press(CNT_MAX - 1 + $urandom_range(0, 20));
      wait_led(4'hf, 2000, "second_done");
      repeat (300) @(negedge clk);
      check_sequence("repeat");

      chk("sclk_period", bad_period, 0);
      chk("sclk_duty", bad_duty, 0);
      chk("mosi_stable", bad_stable, 0);
      chk("partial_bytes", partial, 0);

      clear_mon();
      press(CNT_MAX - 1 + $urandom_range(0, 20));
      wait_led(4'h3, 2000, "abort_pp");
      repeat ($urandom_range(40, 400)) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("abort_cs", 32'(cs), 32'h1);
      chk("abort_led", 32'(led_out), 32'h0);
      chk("abort_sclk", 32'(spi_clk), 32'h0);
      rises_at_rst = rises;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (800) @(negedge clk);
      chk("no_resume_edges", rises, rises_at_rst);
      chk("no_resume_cs", 32'(cs), 32'h1);
      chk("no_resume_led", 32'(led_out), 32'h0);
      chk("idle_lines", bad_idle, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_page_program.md
SPI_PAGE_PROGRAM -- requirements
Module: spi_page_program

Interface
REQ-001 SHALL have parameter CNT_MAX, 1_000_000, debounce length in clk cycles (20 ms at 50 MHz).
REQ-002 SHALL have parameter ADDR, 24'h00_04_25, flash byte address for the page program.
REQ-003 SHALL have parameter DATA_NUM, 10, number of data bytes written (1..256).
REQ-004 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-005 SHALL have port rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-006 SHALL have port key  input  1  raw push-button, active-low, bouncing.
REQ-007 SHALL have port cs  output  1  flash chip select, active-low.
REQ-008 SHALL have port spi_clk  output  1  SPI serial clock, mode 0 (idle low).
REQ-009 SHALL have port spi_mosi  output  1  SPI data to flash, MSB first.
REQ-010 SHALL have port led_out  output  4  status LEDs, active-high.

Function
REQ-011 Debounce: counter SHALL clear while key=1, increment while key=0, and saturate at CNT_MAX-1.
REQ-012 A one-cycle trigger pulse SHALL fire in the cycle the counter reaches CNT_MAX-1; one pulse per press.
REQ-013 FSM states SHALL be IDLE, WREN, GAP, PP, DONE; trigger SHALL be accepted only in IDLE or DONE; triggers elsewhere are ignored.
REQ-014 Bit timing: each bit SHALL span 4 clk cycles (phase 0..3); spi_mosi changes at phase 0; spi_clk=1 in phases 2..3 and 0 otherwise (12.5 MHz); one byte = 32 clk.
REQ-015 Frame: cs SHALL fall the cycle after entry to WREN or PP; one idle 32-clk slot (spi_clk=0) precedes the first byte; bytes follow back-to-back; one idle 32-clk slot follows the last byte; then cs rises.
REQ-016 WREN SHALL send the single byte 8'h06.
REQ-017 GAP SHALL hold cs=1, spi_clk=0 for 32 clk.
REQ-018 PP SHALL send 8'h02, ADDR[23:16], ADDR[15:8], ADDR[7:0], then data bytes 8'h00, 8'h01, ... DATA_NUM-1 (4+DATA_NUM bytes total).
REQ-019 After the PP frame the FSM SHALL enter DONE; a new trigger in DONE restarts at WREN.
REQ-020 spi_mosi SHALL be 0 whenever cs=1 or in idle slots; spi_clk SHALL be 0 whenever cs=1.
REQ-021 led_out SHALL be 4'b0000 in IDLE, 4'b0001 in WREN/GAP, 4'b0011 in PP, and 4'b1111 in DONE.

Reset
REQ-022 On rst_n=0 (asynchronous): cs=1, spi_clk=0, spi_mosi=0, led_out=4'b0000, FSM=IDLE, all counters 0.
REQ-023 Reset asserted mid-frame SHALL abort immediately (cs high at once) and SHALL NOT auto-resume.

Structure
REQ-024 Opcode constants (WREN 8'h06, PP 8'h02) and the FSM state encoding SHALL live in shared package spi_flash_pkg.
REQ-025 The debouncer SHALL be one sub-module, key_filter (clk, rst_n, key_in, key_flag); everything else is in the top.

Verification
REQ-026 Reset, key=1 -> cs=1, spi_clk=0, spi_mosi=0, led_out=0000 held indefinitely.
REQ-027 key low 5 ms then high -> no trigger; cs stays 1; led_out=0000.
REQ-028 key low 20.001 ms (50 MHz clock) -> exactly one trigger; decoded WREN frame = 0x06; cs high 32 clk; PP frame = 02 00 04 25 00 01 ... 09; led_out steps 0001 -> 0011 -> 1111.
REQ-029 Check spi_clk period 80 ns with 50% duty; spi_mosi stable at every spi_clk rising edge.
REQ-030 Second press during PP -> frame unchanged; press in DONE -> full sequence repeats.
REQ-031 rst_n low mid-PP -> cs=1 and led_out=0000 within the same cycle; no further spi_clk edges.
